// File: rtl/spi_slave_regs.sv
// SPI mode-0 slave bridging a two-byte {RW, addr} / data frame onto a simple
// register strobe interface, with all SPI inputs resynchronised into clk.
module spi_slave_regs #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_sck,
    input  logic       spi_cs,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       frame_err
);

    typedef enum logic [1:0] {IDLE, CMD, DATA, HOLD} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] fill;
    logic                   sck_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   sck_d;
    logic                   armed;
    logic [2:0]             bit_cnt;
    logic [6:0]             rx_sr;
    logic [6:0]             tx_sr;
    logic                   rw;
    logic                   rd_load;
    logic                   we_pend;
    logic                   sck_rise;
    logic                   sck_fall;
    logic                   sample_c;
    logic                   cmd_done_c;
    logic                   data_done_c;
    logic                   tx_shift_c;
    logic                   abort_c;

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // Edges only count while the synchronised chip select is asserted.
    assign sck_rise = sck_s & ~sck_d & ~cs_s;
    assign sck_fall = ~sck_s & sck_d & ~cs_s;

    // Input synchronisers; armed stays low after reset until cs is seen high,
    // so a frame already in progress at reset release is skipped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            fill      <= '0;
            sck_d     <= 1'b0;
            armed     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
            sck_d     <= sck_s;
            armed     <= armed | (fill[SYNC_STAGES-1] & cs_s);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next  = state;
        sample_c    = 1'b0;
        cmd_done_c  = 1'b0;
        data_done_c = 1'b0;
        tx_shift_c  = 1'b0;
        abort_c     = 1'b0;
        case (state)
            IDLE: begin
                if (armed && !cs_s) state_next = CMD;
            end
            CMD: begin
                if (cs_s) begin
                    state_next = IDLE;
                    abort_c    = 1'b1;
                end else if (sck_rise) begin
                    sample_c = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        cmd_done_c = 1'b1;
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (cs_s) begin
                    state_next = IDLE;
                    abort_c    = 1'b1;
                end else begin
                    if (sck_rise) begin
                        sample_c = 1'b1;
                        if (bit_cnt == 3'd7) begin
                            data_done_c = 1'b1;
                            state_next  = HOLD;
                        end
                    end
                    // The fall before the first data rise keeps bit 7 on the line.
                    if (sck_fall && bit_cnt != 3'd0) tx_shift_c = 1'b1;
                end
            end
            HOLD: begin
                if (cs_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt     <= 3'd0;
            rx_sr       <= 7'd0;
            tx_sr       <= 7'd0;
            rw          <= 1'b0;
            rd_load     <= 1'b0;
            we_pend     <= 1'b0;
            reg_addr    <= 7'd0;
            reg_wdata   <= 8'd0;
            reg_we      <= 1'b0;
            reg_re      <= 1'b0;
            frame_err   <= 1'b0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
        end else begin
            reg_we    <= we_pend;
            we_pend   <= 1'b0;
            reg_re    <= 1'b0;
            rd_load   <= reg_re;
            frame_err <= abort_c;
            if (state == IDLE) bit_cnt <= 3'd0;
            if (sample_c) begin
                rx_sr   <= {rx_sr[5:0], mosi_s};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (cmd_done_c) begin
                reg_addr <= {rx_sr[5:0], mosi_s};
                rw       <= rx_sr[6];
                reg_re   <= rx_sr[6];
            end
            if (data_done_c && !rw) begin
                reg_wdata <= {rx_sr, mosi_s};
                we_pend   <= 1'b1;
            end
            // Read data arrives the cycle after reg_re.
            if (rd_load && state == DATA && !cs_s) begin
                tx_sr       <= reg_rdata[6:0];
                spi_miso    <= reg_rdata[7];
                spi_miso_oe <= 1'b1;
            end
            if (tx_shift_c) begin
                tx_sr    <= {tx_sr[5:0], 1'b0};
                spi_miso <= tx_sr[6];
            end
            if (state_next == IDLE) begin
                spi_miso    <= 1'b0;
                spi_miso_oe <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_regs.sv
// Directed bench for spi_slave_regs: write, read, abort, overlong frame,
// reset mid-frame and minimum sck half-period.
module tb_spi_slave_regs;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int          HALF        = 8;
    localparam int          HALF_MIN    = SYNC_STAGES + 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       spi_sck;
    logic       spi_cs;
    logic       spi_mosi;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata = 8'hEE;
    logic       frame_err;

    logic [7:0] rd_val = 8'h00;
    int         checks = 0;
    int         errors = 0;
    int         we_cnt = 0;
    int         re_cnt = 0;
    int         ferr_cnt = 0;
    int         both_cnt = 0;
    logic [6:0] we_addr = 7'd0;
    logic [7:0] we_data = 8'd0;
    logic [6:0] re_addr = 7'd0;

    spi_slave_regs #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi_sck     (spi_sck),
        .spi_cs      (spi_cs),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_we      (reg_we),
        .reg_re      (reg_re),
        .reg_rdata   (reg_rdata),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    // Register file model: read data valid only in the cycle after reg_re.
    always @(posedge clk) reg_rdata <= reg_re ? rd_val : 8'hEE;

    always @(negedge clk) begin
        if (reg_we) begin
            we_cnt  = we_cnt + 1;
            we_addr = reg_addr;
            we_data = reg_wdata;
        end
        if (reg_re) begin
            re_cnt  = re_cnt + 1;
            re_addr = reg_addr;
        end
        if (frame_err) ferr_cnt = ferr_cnt + 1;
        if (reg_we && reg_re) both_cnt = both_cnt + 1;
    end

    // Bit i of the frame goes out before rise i+1; miso/oe recorded at each rise.
    task automatic run_frame(input logic [23:0] bits, input int nbits, input int half,
                             output logic [23:0] mbits, output logic [23:0] oebits,
                             output logic oe_after);
        mbits  = '0;
        oebits = '0;
        @(negedge clk);
        spi_cs = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = bits[23-i];
            repeat (half) @(negedge clk);
            mbits[23-i]  = spi_miso;
            oebits[23-i] = spi_miso_oe;
            spi_sck = 1'b1;
            repeat (half) @(negedge clk);
            spi_sck = 1'b0;
        end
        repeat (half) @(negedge clk);
        spi_cs = 1'b1;
        repeat (SYNC_STAGES + 2) @(negedge clk);
        oe_after = spi_miso_oe;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; spi_cs = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
        repeat (4) @(negedge clk);
        checks += 7;
        if (spi_miso !== 1'b0)    begin errors++; $display("FAIL reset_miso got %b exp 0", spi_miso); end
        if (spi_miso_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b exp 0", spi_miso_oe); end
        if (reg_addr !== 7'h00)   begin errors++; $display("FAIL reset_addr got %h exp 00", reg_addr); end
        if (reg_wdata !== 8'h00)  begin errors++; $display("FAIL reset_wdata got %h exp 00", reg_wdata); end
        if (reg_we !== 1'b0)      begin errors++; $display("FAIL reset_we got %b exp 0", reg_we); end
        if (reg_re !== 1'b0)      begin errors++; $display("FAIL reset_re got %b exp 0", reg_re); end
        if (frame_err !== 1'b0)   begin errors++; $display("FAIL reset_ferr got %b exp 0", frame_err); end
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_write;
        int w0, r0, f0;
        logic [23:0] mb, ob;
        logic oa;
        w0 = we_cnt; r0 = re_cnt; f0 = ferr_cnt;
        run_frame(24'h05A500, 16, HALF, mb, ob, oa);
        checks += 6;
        if (we_cnt - w0 !== 1)   begin errors++; $display("FAIL write_we_count got %0d exp 1", we_cnt - w0); end
        if (we_addr !== 7'h05)   begin errors++; $display("FAIL write_addr got %h exp 05", we_addr); end
        if (we_data !== 8'hA5)   begin errors++; $display("FAIL write_data got %h exp a5", we_data); end
        if (re_cnt - r0 !== 0)   begin errors++; $display("FAIL write_re_count got %0d exp 0", re_cnt - r0); end
        if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL write_ferr_count got %0d exp 0", ferr_cnt - f0); end
        if (ob !== 24'h0)        begin errors++; $display("FAIL write_oe got %h exp 000000", ob); end
    endtask

    task automatic test_read;
        int w0, r0, f0;
        logic [23:0] mb, ob;
        logic oa;
        w0 = we_cnt; r0 = re_cnt; f0 = ferr_cnt;
        rd_val = 8'h3C;
        run_frame(24'h850000, 16, HALF, mb, ob, oa);
        checks += 7;
        if (re_cnt - r0 !== 1)     begin errors++; $display("FAIL read_re_count got %0d exp 1", re_cnt - r0); end
        if (re_addr !== 7'h05)     begin errors++; $display("FAIL read_addr got %h exp 05", re_addr); end
        if (mb[15:8] !== 8'h3C)    begin errors++; $display("FAIL read_miso got %h exp 3c", mb[15:8]); end
        if (ob[15:8] !== 8'hFF)    begin errors++; $display("FAIL read_oe got %h exp ff", ob[15:8]); end
        if (oa !== 1'b0)           begin errors++; $display("FAIL read_oe_after_cs got %b exp 0", oa); end
        if (we_cnt - w0 !== 0)     begin errors++; $display("FAIL read_we_count got %0d exp 0", we_cnt - w0); end
        if (ferr_cnt - f0 !== 0)   begin errors++; $display("FAIL read_ferr_count got %0d exp 0", ferr_cnt - f0); end
    endtask

    task automatic test_abort;
        int w0, r0, f0;
        logic [23:0] mb, ob;
        logic oa;
        w0 = we_cnt; r0 = re_cnt; f0 = ferr_cnt;
        run_frame(24'h103300, 12, HALF, mb, ob, oa);
        checks += 3;
        if (ferr_cnt - f0 !== 1) begin errors++; $display("FAIL abort_ferr_count got %0d exp 1", ferr_cnt - f0); end
        if (we_cnt - w0 !== 0)   begin errors++; $display("FAIL abort_we_count got %0d exp 0", we_cnt - w0); end
        if (re_cnt - r0 !== 0)   begin errors++; $display("FAIL abort_re_count got %0d exp 0", re_cnt - r0); end
    endtask

    task automatic test_overlong;
        int w0, r0, f0;
        logic [23:0] mb, ob;
        logic oa;
        w0 = we_cnt; r0 = re_cnt; f0 = ferr_cnt;
        run_frame(24'h021122, 24, HALF, mb, ob, oa);
        checks += 5;
        if (we_cnt - w0 !== 1)   begin errors++; $display("FAIL long_we_count got %0d exp 1", we_cnt - w0); end
        if (we_addr !== 7'h02)   begin errors++; $display("FAIL long_addr got %h exp 02", we_addr); end
        if (we_data !== 8'h11)   begin errors++; $display("FAIL long_data got %h exp 11", we_data); end
        if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL long_ferr_count got %0d exp 0", ferr_cnt - f0); end
        if (re_cnt - r0 !== 0)   begin errors++; $display("FAIL long_re_count got %0d exp 0", re_cnt - r0); end
    endtask

    task automatic test_reset_mid_frame;
        int w0, r0, f0;
        logic [15:0] pat;
        logic [23:0] mb, ob;
        logic oa;
        w0 = we_cnt; r0 = re_cnt; f0 = ferr_cnt;
        pat = 16'h0377;
        @(negedge clk);
        spi_cs = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 4) begin
                rst_n = 1'b0;
                repeat (3) @(negedge clk);
                checks += 7;
                if (spi_miso !== 1'b0)    begin errors++; $display("FAIL mid_reset_miso got %b exp 0", spi_miso); end
                if (spi_miso_oe !== 1'b0) begin errors++; $display("FAIL mid_reset_oe got %b exp 0", spi_miso_oe); end
                if (reg_addr !== 7'h00)   begin errors++; $display("FAIL mid_reset_addr got %h exp 00", reg_addr); end
                if (reg_wdata !== 8'h00)  begin errors++; $display("FAIL mid_reset_wdata got %h exp 00", reg_wdata); end
                if (reg_we !== 1'b0)      begin errors++; $display("FAIL mid_reset_we got %b exp 0", reg_we); end
                if (reg_re !== 1'b0)      begin errors++; $display("FAIL mid_reset_re got %b exp 0", reg_re); end
                if (frame_err !== 1'b0)   begin errors++; $display("FAIL mid_reset_ferr got %b exp 0", frame_err); end
                rst_n = 1'b1;
            end
            spi_mosi = pat[15-i];
            repeat (HALF) @(negedge clk);
            spi_sck = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_sck = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        spi_cs = 1'b1;
        repeat (12) @(negedge clk);
        checks += 3;
        if (we_cnt - w0 !== 0)   begin errors++; $display("FAIL mid_we_count got %0d exp 0", we_cnt - w0); end
        if (re_cnt - r0 !== 0)   begin errors++; $display("FAIL mid_re_count got %0d exp 0", re_cnt - r0); end
        if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL mid_ferr_count got %0d exp 0", ferr_cnt - f0); end
        w0 = we_cnt;
        run_frame(24'h015A00, 16, HALF, mb, ob, oa);
        checks += 3;
        if (we_cnt - w0 !== 1)   begin errors++; $display("FAIL post_we_count got %0d exp 1", we_cnt - w0); end
        if (we_addr !== 7'h01)   begin errors++; $display("FAIL post_addr got %h exp 01", we_addr); end
        if (we_data !== 8'h5A)   begin errors++; $display("FAIL post_data got %h exp 5a", we_data); end
    endtask

    task automatic test_min_timing;
        int r0, f0;
        logic [23:0] mb, ob;
        logic oa;
        r0 = re_cnt; f0 = ferr_cnt;
        rd_val = 8'hC3;
        run_frame(24'hFF0000, 20, HALF_MIN, mb, ob, oa);
        checks += 6;
        if (re_cnt - r0 !== 1)   begin errors++; $display("FAIL fast_re_count got %0d exp 1", re_cnt - r0); end
        if (re_addr !== 7'h7F)   begin errors++; $display("FAIL fast_addr got %h exp 7f", re_addr); end
        if (mb[15:8] !== 8'hC3)  begin errors++; $display("FAIL fast_miso got %h exp c3", mb[15:8]); end
        if (ob[15:8] !== 8'hFF)  begin errors++; $display("FAIL fast_oe got %h exp ff", ob[15:8]); end
        if (mb[7:4] !== 4'hF)    begin errors++; $display("FAIL fast_hold_miso got %h exp f", mb[7:4]); end
        if (ferr_cnt - f0 !== 0) begin errors++; $display("FAIL fast_ferr_count got %0d exp 0", ferr_cnt - f0); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_abort();
        test_overlong();
        test_reset_mid_frame();
        test_min_timing();
        checks++;
        if (both_cnt !== 0) begin errors++; $display("FAIL we_re_same_cycle got %0d exp 0", both_cnt); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_regs.md
SPI_SLAVE_REGS -- requirements
Module: spi_slave_regs

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of flip-flops in each input synchronizer for spi_sck, spi_cs and spi_mosi (legal range 2..3).
REQ-002 SHALL have port clk, input, 1 bit: system clock; all logic SHALL be clocked on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port spi_sck, input, 1 bit: SPI clock from the master (mode 0: CPOL=0, CPHA=0).
REQ-005 SHALL have port spi_cs, input, 1 bit: chip select, active-low.
REQ-006 SHALL have port spi_mosi, input, 1 bit: master-out serial data, MSB first.
REQ-007 SHALL have port spi_miso, output, 1 bit: slave-out serial data, MSB first.
REQ-008 SHALL have port spi_miso_oe, output, 1 bit: miso output enable, high only while driving read data.
REQ-009 SHALL have port reg_addr, output, 7 bits: register address latched from the command byte.
REQ-010 SHALL have port reg_wdata, output, 8 bits: write data latched from the data byte.
REQ-011 SHALL have port reg_we, output, 1 bit: one-clk write strobe.
REQ-012 SHALL have port reg_re, output, 1 bit: one-clk read strobe.
REQ-013 SHALL have port reg_rdata, input, 8 bits: read data, sampled exactly 1 clk after reg_re.
REQ-014 SHALL have port frame_err, output, 1 bit: one-clk pulse on an aborted frame.

Function
REQ-015 SHALL synchronize spi_sck, spi_cs and spi_mosi through SYNC_STAGES flip-flops; sck edges SHALL be detected from the synchronized value and its 1-clk delayed copy.
REQ-016 SHALL require an sck half-period of at least SYNC_STAGES+4 clk; slower sck SHALL be unconstrained.
REQ-017 SHALL define a frame as the span from cs falling to cs rising: byte 0 is {RW, addr[6:0]} with RW=1 meaning read; byte 1 is data; both MSB first.
REQ-018 SHALL sample mosi on detected sck rising edges and shift miso on detected sck falling edges.
REQ-019 SHALL implement states IDLE, CMD, DATA and HOLD, using a 3-bit bit counter that wraps from 7 to 0 at each byte boundary.
REQ-020 SHALL transition IDLE->CMD on synchronized cs low, with the bit counter cleared.
REQ-021 SHALL, on the 8th CMD rising edge, latch reg_addr, latch RW and enter DATA.
REQ-022 SHALL, for a read, pulse reg_re 1 clk after the 8th CMD rising edge, load reg_rdata into the tx shift register 1 clk later, and then assert spi_miso_oe with spi_miso = bit7.
REQ-023 SHALL shift the tx register left on DATA falling edges 1..7, so that bits 6..0 appear in order.
REQ-024 SHALL, for a write, after the 8th DATA rising edge, latch reg_wdata and pulse reg_we 1 clk later; reg_addr and reg_wdata SHALL be stable during the pulse.
REQ-025 SHALL, after the 8th DATA rising edge, enter HOLD for both read and write; in HOLD, further sck edges SHALL be ignored and miso SHALL hold its last bit.
REQ-026 SHALL, when cs goes high in any state, return to IDLE and deassert spi_miso_oe within 1 clk of the synchronized cs edge.
REQ-027 SHALL, when cs goes high in CMD or DATA, abort the frame: pulse frame_err, suppress reg_we, and issue no further reg_re.
REQ-028 SHALL ignore sck edges while the synchronized cs is high.
REQ-029 SHALL, if sck is high when cs falls, not count that level as an edge.
REQ-030 SHALL never assert reg_we and reg_re in the same clk, and SHALL allow at most one of them per frame.
REQ-031 SHALL drive spi_miso to 0 whenever spi_miso_oe is low.

Reset
REQ-032 SHALL, while rst_n is low, force state IDLE, bit counter 0, spi_miso 0, spi_miso_oe 0, reg_addr 0, reg_wdata 0, reg_we 0, reg_re 0, frame_err 0, and all synchronizer flops to 1 for cs and 0 for sck and mosi.
REQ-033 SHALL, on reset asserted mid-frame, discard the frame without a reg_we or frame_err pulse; after release, the frame still in progress SHALL be ignored until cs goes high.

Verification
REQ-034 Bench SHALL cover a write: cs low, mosi 0x05 then 0xA5, cs high -> exactly one reg_we with reg_addr=0x05 and reg_wdata=0xA5, no reg_re, no frame_err.
REQ-035 Bench SHALL cover a read: mosi 0x85 with reg_rdata=0x3C -> exactly one reg_re with reg_addr=0x05, miso bits 0,0,1,1,1,1,0,0 sampled on rising edges 9..16, spi_miso_oe high from before rising edge 9 until cs high.
REQ-036 Bench SHALL cover an abort: cs high after 12 bits of a write to 0x10 -> frame_err pulses once, no reg_we.
REQ-037 Bench SHALL cover an overlong frame: 24 sck cycles with bytes 0x02, 0x11, 0x22 -> one reg_we with addr 0x02 and data 0x11, third byte ignored, no frame_err.
REQ-038 Bench SHALL cover reset mid-frame: rst_n low after 4 bits, released while cs is still low -> all outputs at reset values, no strobes, and the next full frame 0x01/0x5A writes correctly.
REQ-039 Bench SHALL cover minimum timing: sck half-period = SYNC_STAGES+4 clk on a read of 0x7F -> correct miso data, with reg_re and the tx load completing before rising edge 9.
